// File: rtl/pulse_stretcher.sv
// Purpose: stretch single-cycle triggers into a registered level held for max(len,1) cycles.
// Latency: level_out rises on the edge that samples pulse_in=1; done strobes on the edge it falls.
// Backpressure: none; triggers that cannot be honoured are dropped and counted in drop_cnt.
//
// Ports: clk, rst (async, active-low), pulse_in, len[LEN_W-1:0] in;
//        level_out, busy, done, drop_cnt[CNT_W-1:0] out (all registered).
// Optional hold-off window after each stretch: define PULSE_STRETCHER_HOLDOFF_EN
// (active only when HOLDOFF > 0).
module pulse_stretcher #(
    parameter int LEN_W   = 8,
    parameter int CNT_W   = 8,
    parameter int RETRIG  = 0,
    parameter int HOLDOFF = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic [LEN_W-1:0] len,
    output logic             level_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] drop_cnt
);

`ifdef PULSE_STRETCHER_HOLDOFF_EN
    localparam bit HO_EN = (HOLDOFF > 0);
    // Wide enough to hold HOLDOFF-1.
    localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF - 1);
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HOLDOFF} state_t;
    logic [HO_W-1:0] ho_q, ho_d;
`else
    // Hold-off compiled out; HOLDOFF is referenced only so the parameter
    // list stays identical across builds.
    localparam bit HO_EN = 1'b0 && (HOLDOFF > 0);
    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;
`endif

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             drop_inc;
    logic [LEN_W-1:0] len_m1;

    // len=0 behaves like len=1; cnt holds remaining edges before the final one.
    assign len_m1 = (len == '0) ? '0 : len - LEN_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        drop_inc = 1'b0;
`ifdef PULSE_STRETCHER_HOLDOFF_EN
        ho_d     = ho_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pulse_in) begin
                    cnt_d   = len_m1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (pulse_in) begin
                        if (RETRIG != 0) cnt_d = len_m1;
                        else             drop_inc = 1'b1;
                    end
                end else begin
                    done_d = 1'b1;
                    if (pulse_in && !HO_EN) begin
                        // Trigger on the final edge joins seamlessly into a new stretch.
                        cnt_d = len_m1;
                    end else begin
                        if (pulse_in) drop_inc = 1'b1;
`ifdef PULSE_STRETCHER_HOLDOFF_EN
                        if (HO_EN) begin
                            state_d = ST_HOLDOFF;
                            ho_d    = HO_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef PULSE_STRETCHER_HOLDOFF_EN
            ST_HOLDOFF: begin
                if (pulse_in) drop_inc = 1'b1;
                if (ho_q == '0) state_d = ST_IDLE;
                else            ho_d    = ho_q - HO_W'(1);
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered copies of what the next state implies.
        level_d = (state_d == ST_ACTIVE);
        busy_d  = (state_d != ST_IDLE);

        drop_d = drop_q;
        if (drop_inc && (drop_q != {CNT_W{1'b1}})) drop_d = drop_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= '0;
`ifdef PULSE_STRETCHER_HOLDOFF_EN
            ho_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
`ifdef PULSE_STRETCHER_HOLDOFF_EN
            ho_q    <= ho_d;
`endif
        end
    end

    assign level_out = level_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pulse_in = 1'b0;
    logic [7:0] len = 8'd0;

    // dut0: RETRIG=0, dut1: RETRIG=1, dut2: CNT_W=2. All see the same stimulus.
    logic       level0, busy0, done0;
    logic [7:0] drop0;
    logic       level1, busy1, done1;
    logic [7:0] drop1;
    logic       level2, busy2, done2;
    logic [1:0] drop2;

    int n_tests = 0;
    int n_fail  = 0;

    // Results of the last measure() run.
    int w0, w1, d0, d1, fd0, fh0, bm;

    always #5 clk = ~clk;

    pulse_stretcher #(.LEN_W(8), .CNT_W(8), .RETRIG(0), .HOLDOFF(0)) dut0 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .len(len),
        .level_out(level0), .busy(busy0), .done(done0), .drop_cnt(drop0));

    pulse_stretcher #(.LEN_W(8), .CNT_W(8), .RETRIG(1), .HOLDOFF(0)) dut1 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .len(len),
        .level_out(level1), .busy(busy1), .done(done1), .drop_cnt(drop1));

    pulse_stretcher #(.LEN_W(8), .CNT_W(2), .RETRIG(0), .HOLDOFF(0)) dut2 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .len(len),
        .level_out(level2), .busy(busy2), .done(done2), .drop_cnt(drop2));

`ifdef PULSE_STRETCHER_HOLDOFF_EN
    logic       level3, busy3, done3;
    logic [7:0] drop3;
    pulse_stretcher #(.LEN_W(8), .CNT_W(8), .RETRIG(0), .HOLDOFF(4)) dut3 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .len(len),
        .level_out(level3), .busy(busy3), .done(done3), .drop_cnt(drop3));
`endif

    task automatic do_reset();
        pulse_in = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Trigger at sample 0, optional extra pulses at samples ex_at..ex_at+ex_n-1.
    // Sample k is taken on the negedge after posedge k.
    task automatic measure(input logic [7:0] l, input int ex_at, input int ex_n);
        w0 = 0; w1 = 0; d0 = 0; d1 = 0; fd0 = -1; fh0 = -1; bm = 0;
        len = l;
        for (int k = 0; k < 600; k++) begin
            pulse_in = (k == 0) || (ex_at >= 0 && k >= ex_at && k < ex_at + ex_n);
            @(negedge clk);
            if (level0) begin w0++; if (fh0 < 0) fh0 = k; end
            if (level1) w1++;
            if (done0) begin d0++; if (fd0 < 0) fd0 = k; end
            if (done1) d1++;
            if (busy0 !== level0) bm++;
            if (!level0 && !level1 && !level2 && k >= ex_at + ex_n) break;
        end
        pulse_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({level0, busy0, done0, drop0} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_state: got lvl=%b busy=%b done=%b drop=%0d, want all 0",
                     level0, busy0, done0, drop0);
        end
        do_reset();
        n_tests++;
        if ({level1, busy1, done1, drop1, level2, drop2} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_state_variants: got lvl1=%b busy1=%b done1=%b drop1=%0d lvl2=%b drop2=%0d, want all 0",
                     level1, busy1, done1, drop1, level2, drop2);
        end
    endtask

    task automatic test_basic();
        do_reset();
        measure(8'd5, -1, 0);
        n_tests++;
        if (w0 !== 5) begin n_fail++; $display("FAIL len5_width: got %0d want 5", w0); end
        n_tests++;
        if (fh0 !== 0) begin n_fail++; $display("FAIL len5_rise_latency: got sample %0d want 0", fh0); end
        n_tests++;
        if (d0 !== 1 || fd0 !== 5) begin
            n_fail++; $display("FAIL len5_done: got count %0d at %0d want 1 at 5", d0, fd0);
        end
        n_tests++;
        if (bm !== 0) begin n_fail++; $display("FAIL len5_busy_mirror: got %0d mismatches want 0", bm); end
        n_tests++;
        if (drop0 !== 8'd0) begin n_fail++; $display("FAIL len5_drop: got %0d want 0", drop0); end
    endtask

    task automatic test_len_bounds();
        do_reset();
        measure(8'd0, -1, 0);
        n_tests++;
        if (w0 !== 1 || fd0 !== 1) begin
            n_fail++; $display("FAIL len0: got width %0d done at %0d want width 1 done at 1", w0, fd0);
        end
        measure(8'd1, -1, 0);
        n_tests++;
        if (w0 !== 1 || fd0 !== 1) begin
            n_fail++; $display("FAIL len1: got width %0d done at %0d want width 1 done at 1", w0, fd0);
        end
        measure(8'd255, -1, 0);
        n_tests++;
        if (w0 !== 255 || d0 !== 1) begin
            n_fail++; $display("FAIL len255: got width %0d dones %0d want 255 and 1", w0, d0);
        end
    endtask

    task automatic test_retrigger();
        do_reset();
        measure(8'd6, 3, 1);
        n_tests++;
        if (w0 !== 6 || drop0 !== 8'd1) begin
            n_fail++; $display("FAIL retrig0: got width %0d drop %0d want 6 and 1", w0, drop0);
        end
        n_tests++;
        if (w1 !== 9 || drop1 !== 8'd0 || d1 !== 1) begin
            n_fail++; $display("FAIL retrig1: got width %0d drop %0d dones %0d want 9, 0, 1", w1, drop1, d1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // len=4: final ACTIVE edge is posedge 4.
        measure(8'd4, 4, 1);
        n_tests++;
        if (w0 !== 8 || w1 !== 8) begin
            n_fail++; $display("FAIL join_width: got %0d/%0d want 8/8", w0, w1);
        end
        n_tests++;
        if (d0 !== 2 || fd0 !== 4) begin
            n_fail++; $display("FAIL join_done: got count %0d first at %0d want 2 first at 4", d0, fd0);
        end
        n_tests++;
        if (drop0 !== 8'd0 || drop1 !== 8'd0) begin
            n_fail++; $display("FAIL join_drop: got %0d/%0d want 0/0", drop0, drop1);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        measure(8'd20, 2, 5);
        n_tests++;
        if (drop2 !== 2'd3) begin n_fail++; $display("FAIL drop_saturate: got %0d want 3", drop2); end
        n_tests++;
        if (drop0 !== 8'd5) begin n_fail++; $display("FAIL drop_count8: got %0d want 5", drop0); end
    endtask

    task automatic test_async_reset();
        int dn;
        do_reset();
        len = 8'd10;
        pulse_in = 1'b1;
        @(negedge clk);          // posedge 0 accepted
        @(negedge clk);          // posedge 1 drops the held pulse
        pulse_in = 1'b0;
        @(negedge clk);          // posedge 2
        #2;
        rst = 1'b0;
        #1;                      // still before the next posedge
        n_tests++;
        if ({level0, busy0, done0, drop0} !== 11'd0) begin
            n_fail++;
            $display("FAIL async_reset: got lvl=%b busy=%b done=%b drop=%0d, want all 0",
                     level0, busy0, done0, drop0);
        end
        dn = 0;
        repeat (3) begin @(negedge clk); if (done0 || level0) dn++; end
        rst = 1'b1;
        repeat (12) begin @(negedge clk); if (done0 || level0) dn++; end
        n_tests++;
        if (dn !== 0) begin n_fail++; $display("FAIL reset_no_done: got %0d active samples want 0", dn); end
    endtask

`ifdef PULSE_STRETCHER_HOLDOFF_EN
    task automatic test_holdoff();
        int bw, lw;
        do_reset();
        bw = 0; lw = 0;
        len = 8'd2;
        for (int k = 0; k < 12; k++) begin
            pulse_in = (k == 0) || (k == 4);
            @(negedge clk);
            if (busy3) bw++;
            if (level3) lw++;
        end
        pulse_in = 1'b0;
        n_tests++;
        if (bw !== 6) begin n_fail++; $display("FAIL holdoff_busy: got %0d want 6", bw); end
        n_tests++;
        if (lw !== 2 || drop3 !== 8'd1) begin
            n_fail++; $display("FAIL holdoff_drop: got level %0d drop %0d want 2 and 1", lw, drop3);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_len_bounds();
        test_retrigger();
        test_back_to_back();
        test_saturate();
        test_async_reset();
`ifdef PULSE_STRETCHER_HOLDOFF_EN
        test_holdoff();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
